// File: rtl/core_lsu.sv
// core_lsu: load/store unit between execute and the data-memory port.
// One transaction in flight; execute stalls on lsu_ready_o (high only in IDLE).
// Optional macro CORE_LSU_MISALIGN_EXC_EN: misaligned half/word accesses skip
// memory and complete through a one-cycle ERR state with lsu_misalign_o.
module core_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_signed_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic [4:0]        lsu_rd_addr_i,
  output logic              lsu_done_o,
  output logic              lsu_rd_we_o,
  output logic [4:0]        lsu_rd_addr_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_misalign_o,
  output logic              data_mem_req_o,
  input  logic              data_mem_grnt_i,
  output logic [ADDR_W-1:0] data_mem_addr_o,
  output logic [DATA_W-1:0] data_mem_wdata_o,
  output logic [DATA_W/8-1:0] data_mem_be_o,
  output logic              data_mem_wen_o,
  output logic              data_mem_ren_o,
  input  logic [DATA_W-1:0] data_mem_rdata_i,
  input  logic              data_mem_rvalid_i
);

`ifdef CORE_LSU_MISALIGN_EXC_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
`endif

  state_t state_q, state_d;

  logic              accept;
  logic              mis_acc;
  logic [3:0]        be_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;

  // Captured operation attributes needed at response time
  logic [1:0]        size_q;
  logic              signed_q;
  logic              we_q;
  logic [1:0]        addr_lo_q;
  logic [4:0]        rd_q;

  logic              done_q, rd_we_q, misalign_q;
  logic [4:0]        rd_addr_q;
  logic [DATA_W-1:0] rdata_q;

  assign accept      = lsu_valid_i && (state_q == S_IDLE);
  assign lsu_ready_o = (state_q == S_IDLE);

`ifdef CORE_LSU_MISALIGN_EXC_EN
  assign mis_acc = (lsu_size_i == 2'b01 && lsu_addr_i[0]) ||
                   (lsu_size_i[1] && (lsu_addr_i[1:0] != 2'b00));
`else
  assign mis_acc = 1'b0;
`endif

  // Store lane replication and byte enables from the incoming request
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = lsu_wdata_i;
    case (lsu_size_i)
      2'b00: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = lsu_wdata_i;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    shifted  = data_mem_rdata_i >> {addr_lo_q, 3'b000};
    load_ext = data_mem_rdata_i;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = data_mem_rdata_i;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef CORE_LSU_MISALIGN_EXC_EN
          state_d = mis_acc ? S_ERR : S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ:   if (data_mem_grnt_i)   state_d = S_RESP;
      S_RESP:  if (data_mem_rvalid_i) state_d = S_IDLE;
`ifdef CORE_LSU_MISALIGN_EXC_EN
      S_ERR:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Request, capture and completion registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_mem_req_o   <= 1'b0;
      data_mem_addr_o  <= '0;
      data_mem_wdata_o <= '0;
      data_mem_be_o    <= '0;
      data_mem_wen_o   <= 1'b0;
      data_mem_ren_o   <= 1'b0;
      size_q           <= '0;
      signed_q         <= 1'b0;
      we_q             <= 1'b0;
      addr_lo_q        <= '0;
      rd_q             <= '0;
      done_q           <= 1'b0;
      rd_we_q          <= 1'b0;
      misalign_q       <= 1'b0;
      rd_addr_q        <= '0;
      rdata_q          <= '0;
    end else begin
      done_q     <= 1'b0;
      rd_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      if (accept) begin
        size_q    <= lsu_size_i;
        signed_q  <= lsu_signed_i;
        we_q      <= lsu_we_i;
        addr_lo_q <= lsu_addr_i[1:0];
        rd_q      <= lsu_rd_addr_i;
        if (mis_acc) begin
          done_q     <= 1'b1;
          misalign_q <= 1'b1;
        end else begin
          data_mem_req_o   <= 1'b1;
          data_mem_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
          data_mem_be_o    <= be_d;
          data_mem_wdata_o <= wdata_d;
          data_mem_wen_o   <= lsu_we_i;
          data_mem_ren_o   <= ~lsu_we_i;
        end
      end
      if (state_q == S_REQ && data_mem_grnt_i) begin
        data_mem_req_o <= 1'b0;
        data_mem_wen_o <= 1'b0;
        data_mem_ren_o <= 1'b0;
      end
      if (state_q == S_RESP && data_mem_rvalid_i) begin
        done_q  <= 1'b1;
        rd_we_q <= ~we_q;
        if (!we_q) begin
          rdata_q   <= load_ext;
          rd_addr_q <= rd_q;
        end
      end
    end
  end

  assign lsu_done_o    = done_q;
  assign lsu_rd_we_o   = rd_we_q;
  assign lsu_rd_addr_o = rd_addr_q;
  assign lsu_rdata_o   = rdata_q;
`ifdef CORE_LSU_MISALIGN_EXC_EN
  assign lsu_misalign_o = misalign_q;
`else
  assign lsu_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_core_lsu.sv
// Directed testbench for core_lsu; inputs driven and outputs sampled on negedge.
module tb_core_lsu;
  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        lsu_valid_i, lsu_ready_o, lsu_we_i, lsu_signed_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [4:0]  lsu_rd_addr_i, lsu_rd_addr_o;
  logic        lsu_done_o, lsu_rd_we_o, lsu_misalign_o;
  logic [31:0] lsu_rdata_o;
  logic        data_mem_req_o, data_mem_grnt_i, data_mem_wen_o, data_mem_ren_o, data_mem_rvalid_i;
  logic [31:0] data_mem_addr_o, data_mem_wdata_o, data_mem_rdata_i;
  logic [3:0]  data_mem_be_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  core_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i), .lsu_signed_i(lsu_signed_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rd_addr_i(lsu_rd_addr_i),
    .lsu_done_o(lsu_done_o), .lsu_rd_we_o(lsu_rd_we_o), .lsu_rd_addr_o(lsu_rd_addr_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_misalign_o(lsu_misalign_o),
    .data_mem_req_o(data_mem_req_o), .data_mem_grnt_i(data_mem_grnt_i),
    .data_mem_addr_o(data_mem_addr_o), .data_mem_wdata_o(data_mem_wdata_o),
    .data_mem_be_o(data_mem_be_o), .data_mem_wen_o(data_mem_wen_o),
    .data_mem_ren_o(data_mem_ren_o), .data_mem_rdata_i(data_mem_rdata_i),
    .data_mem_rvalid_i(data_mem_rvalid_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one operation from a negedge in IDLE; returns at the negedge of the
  // done cycle so a following call exercises a back-to-back accept.
  task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int gstall, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    check({tag, ".ready_idle"}, 32'(lsu_ready_o), 32'd1);
    lsu_valid_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_signed_i = sgn;
    lsu_addr_i = addr; lsu_wdata_i = wdata; lsu_rd_addr_i = rd;
    @(negedge clk_i);
    lsu_valid_i = 1'b0;
    check({tag, ".done_low"}, 32'(lsu_done_o), 32'd0);
    for (int i = 0; i <= gstall; i++) begin
      check({tag, ".req"},   32'(data_mem_req_o), 32'd1);
      check({tag, ".ready"}, 32'(lsu_ready_o), 32'd0);
      check({tag, ".addr"},  data_mem_addr_o, exp_addr);
      check({tag, ".be"},    32'(data_mem_be_o), 32'(exp_be));
      check({tag, ".wen"},   32'(data_mem_wen_o), 32'(we));
      check({tag, ".ren"},   32'(data_mem_ren_o), 32'(!we));
      if (we) check({tag, ".wdata"}, data_mem_wdata_o, exp_wdata);
      data_mem_grnt_i = (i == gstall);
      @(negedge clk_i);
    end
    data_mem_grnt_i = 1'b0;
    check({tag, ".req_drop"}, 32'({data_mem_req_o, data_mem_wen_o, data_mem_ren_o}), 32'd0);
    check({tag, ".no_early_done"}, 32'(lsu_done_o), 32'd0);
    data_mem_rvalid_i = 1'b1; data_mem_rdata_i = rdata;
    @(negedge clk_i);
    data_mem_rvalid_i = 1'b0; data_mem_rdata_i = '0;
    check({tag, ".done"},  32'(lsu_done_o), 32'd1);
    check({tag, ".rd_we"}, 32'(lsu_rd_we_o), 32'(!we));
    check({tag, ".misalign"}, 32'(lsu_misalign_o), 32'd0);
    check({tag, ".ready_done"}, 32'(lsu_ready_o), 32'd1);
    if (!we) begin
      check({tag, ".rdata"}, lsu_rdata_o, exp_rdata);
      check({tag, ".rd_addr"}, 32'(lsu_rd_addr_o), 32'(rd));
    end
  endtask

  task automatic idle_tick(input string tag);
    @(negedge clk_i);
    check({tag, ".done_pulse_end"}, 32'(lsu_done_o), 32'd0);
  endtask

  initial begin
    arst_i = 1'b1; lsu_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = '0; lsu_signed_i = 1'b0;
    lsu_addr_i = '0; lsu_wdata_i = '0; lsu_rd_addr_i = '0;
    data_mem_grnt_i = 1'b0; data_mem_rvalid_i = 1'b0; data_mem_rdata_i = '0;
    @(negedge clk_i); @(negedge clk_i);
    check("rst.ready", 32'(lsu_ready_o), 32'd1);
    check("rst.req",   32'(data_mem_req_o), 32'd0);
    check("rst.outs",  32'({lsu_done_o, lsu_rd_we_o, lsu_misalign_o, data_mem_wen_o, data_mem_ren_o}), 32'd0);
    check("rst.rdata", lsu_rdata_o, 32'd0);
    arst_i = 1'b0;
    @(negedge clk_i);

    // Aligned word store, minimum latency
    run_op("st_w", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0, 0, 32'h0,
           32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    idle_tick("st_w");
    // Signed / unsigned byte load at 0x203
    run_op("ld_bs", 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 5'd7, 0, 32'h80FFFF00,
           32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
    idle_tick("ld_bs");
    run_op("ld_bu", 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 5'd8, 0, 32'h80FFFF00,
           32'h200, 4'b1000, 32'h0, 32'h00000080);
    idle_tick("ld_bu");
    // Half store and half loads
    run_op("st_h", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD, 5'd0, 0, 32'h0,
           32'h10, 4'b1100, 32'hABCDABCD, 32'h0);
    idle_tick("st_h");
    run_op("ld_hu", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 5'd9, 0, 32'h12345678,
           32'h10, 4'b1100, 32'h0, 32'h00001234);
    idle_tick("ld_hu");
    run_op("ld_hs", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 5'd10, 0, 32'h00008001,
           32'h10, 4'b0011, 32'h0, 32'hFFFF8001);
    idle_tick("ld_hs");
    // Grant stall of 4 cycles then back-to-back load accepted in the done cycle
    run_op("st_b_stall", 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 5'd0, 4, 32'h0,
           32'h100, 4'b0010, 32'h5A5A5A5A, 32'h0);
    run_op("ld_w_b2b", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5'd31, 1, 32'hCAFEF00D,
           32'h104, 4'b1111, 32'h0, 32'hCAFEF00D);
    idle_tick("ld_w_b2b");

    // Reset while request pending: req drops asynchronously
    lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h300;
    @(negedge clk_i);
    lsu_valid_i = 1'b0;
    check("rst_req.req_before", 32'(data_mem_req_o), 32'd1);
    arst_i = 1'b1; #1;
    check("rst_req.req_async", 32'(data_mem_req_o), 32'd0);
    check("rst_req.ready", 32'(lsu_ready_o), 32'd1);
    @(negedge clk_i); arst_i = 1'b0;
    @(negedge clk_i);

    // Reset while in RESP, late rvalid afterwards
    lsu_valid_i = 1'b1; lsu_addr_i = 32'h304; lsu_rd_addr_i = 5'd3;
    @(negedge clk_i);
    lsu_valid_i = 1'b0; data_mem_grnt_i = 1'b1;
    @(negedge clk_i);
    data_mem_grnt_i = 1'b0;
    check("rst_resp.ready_before", 32'(lsu_ready_o), 32'd0);
    arst_i = 1'b1; #1;
    check("rst_resp.ready", 32'(lsu_ready_o), 32'd1);
    check("rst_resp.req", 32'(data_mem_req_o), 32'd0);
    @(negedge clk_i); arst_i = 1'b0; data_mem_rvalid_i = 1'b1; data_mem_rdata_i = 32'h55AA55AA;
    @(negedge clk_i); data_mem_rvalid_i = 1'b0;
    check("rst_resp.no_done", 32'(lsu_done_o), 32'd0);
    check("rst_resp.no_rd_we", 32'(lsu_rd_we_o), 32'd0);
    @(negedge clk_i);
    check("rst_resp.no_done2", 32'(lsu_done_o), 32'd0);
    check("rst_resp.ready_after", 32'(lsu_ready_o), 32'd1);
    check("rst_resp.rdata", lsu_rdata_o, 32'd0);

    // Misaligned word load at 0x102
`ifdef CORE_LSU_MISALIGN_EXC_EN
    lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h102; lsu_rd_addr_i = 5'd4;
    @(negedge clk_i);
    lsu_valid_i = 1'b0;
    check("mis.req", 32'(data_mem_req_o), 32'd0);
    check("mis.done", 32'(lsu_done_o), 32'd1);
    check("mis.flag", 32'(lsu_misalign_o), 32'd1);
    check("mis.rd_we", 32'(lsu_rd_we_o), 32'd0);
    check("mis.ready_err", 32'(lsu_ready_o), 32'd0);
    @(negedge clk_i);
    check("mis.done_end", 32'({lsu_done_o, lsu_misalign_o, data_mem_req_o}), 32'd0);
    check("mis.ready_after", 32'(lsu_ready_o), 32'd1);
`else
    run_op("mis_w", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 5'd4, 0, 32'h11223344,
           32'h100, 4'b1111, 32'h0, 32'h11223344);
    idle_tick("mis_w");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
